// File: rtl/mips_pkg.sv
// Shared MIPS core types for the multiply/divide unit: opcodes, control states
// and the fixed iteration count of the radix-2 datapath.
package mips_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ITER = 2'b01,
        POST = 2'b10
    } mdu_state_t;

    localparam int MDU_ITERS = 32;

    function automatic logic mdu_is_signed(input mdu_op_t op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor in W+1 bits and keep the difference when no borrow occurs.
module mdu_div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic         in_bit,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);

    logic [W:0] shifted;
    logic [W:0] diff;

    // The remainder is always below the divisor, so the shifted value fits in
    // W+1 bits and the top bit of the difference is exactly the borrow.
    always_comb begin
        shifted  = {rem, in_bit};
        diff     = shifted - {1'b0, divisor};
        q_bit    = ~diff[W];
        rem_next = q_bit ? diff[W-1:0] : shifted[W-1:0];
    end

endmodule

// File: rtl/mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Divide support is compiled in only when MDU_DIV_EN is defined.
module mdu
    import mips_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  mdu_op_t         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CW = $clog2(MDU_ITERS);
    localparam logic [CW-1:0] LAST = CW'(MDU_ITERS - 1);

    mdu_state_t state, next_state;
    mdu_op_t op_q;
    logic [CW-1:0] cnt;
    logic [XLEN-1:0] opnd_a, opnd_b;
    logic [2*XLEN-1:0] work;
    logic neg_main;
    logic accept, done_next;
    logic op_signed;
    logic [XLEN-1:0] abs_a, abs_b;
    logic [XLEN:0] mul_sum;
    logic [2*XLEN-1:0] product;

`ifdef MDU_DIV_EN
    logic neg_rem;
    logic [XLEN-1:0] div_rem;
    logic div_q;
    logic [XLEN-1:0] quotient, remainder;

    mdu_div_step #(.W(XLEN)) u_div_step (
        .rem      (work[2*XLEN-1:XLEN]),
        .in_bit   (opnd_a[XLEN-1]),
        .divisor  (opnd_b),
        .rem_next (div_rem),
        .q_bit    (div_q)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != IDLE);
            done  <= done_next;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        done_next  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
`ifdef MDU_DIV_EN
                    accept     = 1'b1;
                    next_state = ITER;
`else
                    // Without divide hardware a DIV/DIVU completes at once and leaves HI/LO alone.
                    if (op == MDU_DIV || op == MDU_DIVU) begin
                        done_next = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        next_state = ITER;
                    end
`endif
                end
            end
            ITER: begin
                if (cnt == LAST) begin
                    next_state = POST;
                end
            end
            POST: begin
                next_state = IDLE;
                done_next  = 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        op_signed = mdu_is_signed(op);
        abs_a     = (op_signed && a[XLEN-1]) ? -a : a;
        abs_b     = (op_signed && b[XLEN-1]) ? -b : b;
        mul_sum   = {1'b0, work[2*XLEN-1:XLEN]} + (opnd_b[0] ? {1'b0, opnd_a} : '0);
        product   = neg_main ? -work : work;
`ifdef MDU_DIV_EN
        quotient  = neg_main ? -work[XLEN-1:0] : work[XLEN-1:0];
        remainder = neg_rem ? -work[2*XLEN-1:XLEN] : work[2*XLEN-1:XLEN];
`endif
    end

    // A zero divisor clears the quotient sign so LO stays all ones, while the
    // remainder fix restores the original signed dividend in HI.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= MDU_MULT;
            opnd_a   <= '0;
            opnd_b   <= '0;
            work     <= '0;
            cnt      <= '0;
            neg_main <= 1'b0;
`ifdef MDU_DIV_EN
            neg_rem  <= 1'b0;
`endif
            hi       <= '0;
            lo       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_q     <= op;
                        opnd_a   <= abs_a;
                        opnd_b   <= abs_b;
                        work     <= '0;
                        cnt      <= '0;
                        neg_main <= op_signed && (a[XLEN-1] ^ b[XLEN-1]) && (|b);
`ifdef MDU_DIV_EN
                        neg_rem  <= op_signed && a[XLEN-1];
`endif
                    end else if (!start) begin
                        if (hi_we) begin
                            hi <= wdata;
                        end
                        if (lo_we) begin
                            lo <= wdata;
                        end
                    end
                end
                ITER: begin
                    cnt <= cnt + CW'(1);
`ifdef MDU_DIV_EN
                    if (op_q == MDU_DIV || op_q == MDU_DIVU) begin
                        work   <= {div_rem, work[XLEN-2:0], div_q};
                        opnd_a <= opnd_a << 1;
                    end else begin
                        work   <= {mul_sum, work[XLEN-1:1]};
                        opnd_b <= opnd_b >> 1;
                    end
`else
                    work   <= {mul_sum, work[XLEN-1:1]};
                    opnd_b <= opnd_b >> 1;
`endif
                end
                POST: begin
`ifdef MDU_DIV_EN
                    if (op_q == MDU_DIV || op_q == MDU_DIVU) begin
                        hi <= remainder;
                        lo <= quotient;
                    end else begin
                        hi <= product[2*XLEN-1:XLEN];
                        lo <= product[XLEN-1:0];
                    end
`else
                    if (op_q == MDU_MULT || op_q == MDU_MULTU) begin
                        hi <= product[2*XLEN-1:XLEN];
                        lo <= product[XLEN-1:0];
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Randomized self-checking bench for mdu against a plain-arithmetic HI/LO model;
// expectations follow whether MDU_DIV_EN is defined for the build.
module tb_mdu;
    import mips_pkg::*;

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, hi_we, lo_we;
    mdu_op_t     op;
    logic [31:0] a, b, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checkCount = 0;
    int passCount = 0;
    logic [31:0] expHi = '0;
    logic [31:0] expLo = '0;

    mdu #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Architectural result of one operation, straight from signed/unsigned arithmetic.
    task automatic refModel(input logic [1:0] opv, input logic [31:0] av, input logic [31:0] bv);
        longint sa, sb;
        logic [63:0] p;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        case (opv)
            2'd0: begin
                p = sa * sb;
                expHi = p[63:32];
                expLo = p[31:0];
            end
            2'd1: begin
                p = {32'b0, av} * {32'b0, bv};
                expHi = p[63:32];
                expLo = p[31:0];
            end
            default: begin
`ifdef MDU_DIV_EN
                if (bv == 32'd0) begin
                    expHi = av;
                    expLo = 32'hFFFF_FFFF;
                end else if (opv == 2'd2) begin
                    expLo = 32'(sa / sb);
                    expHi = 32'(sa % sb);
                end else begin
                    expLo = av / bv;
                    expHi = av % bv;
                end
`endif
            end
        endcase
    endtask

    task automatic applyStimulus(input logic [1:0] opv, input logic [31:0] av, input logic [31:0] bv,
                                 input bit immediate, input bit disturb, input bit collide);
        int cyc, busyCycles, expLat;
        bit stub;
        stub = opv[1] && !DIV_EN;
        expLat = stub ? 0 : 33;
        if (!immediate) @(negedge clk);
        start = 1'b1;
        op = mdu_op_t'(opv);
        a = av;
        b = bv;
        if (collide) begin
            hi_we = 1'b1;
            lo_we = 1'b1;
            wdata = 32'hCAFE_F00D;
        end
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        a = $urandom;
        b = $urandom;
        cyc = 0;
        busyCycles = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) busyCycles++;
            if (disturb && cyc == 10) begin
                start = 1'b1;
                op = MDU_MULTU;
                a = $urandom;
                b = $urandom;
                hi_we = 1'b1;
                lo_we = 1'b1;
                wdata = 32'hDEAD_BEEF;
            end
            if (cyc == 11) begin
                start = 1'b0;
                hi_we = 1'b0;
                lo_we = 1'b0;
            end
            if (cyc == 20) begin
                checkOutput($sformatf("op%0d hiHeld", opv), hi, expHi);
                checkOutput($sformatf("op%0d loHeld", opv), lo, expLo);
            end
            @(negedge clk);
            cyc++;
        end
        checkOutput($sformatf("op%0d doneSeen", opv), done, 1);
        checkOutput($sformatf("op%0d latency", opv), cyc, expLat);
        checkOutput($sformatf("op%0d busyCycles", opv), busyCycles, expLat);
        checkOutput($sformatf("op%0d busyAtDone", opv), busy, 0);
        refModel(opv, av, bv);
        checkOutput($sformatf("op%0d hi a=%0h b=%0h", opv, av, bv), hi, expHi);
        checkOutput($sformatf("op%0d lo a=%0h b=%0h", opv, av, bv), lo, expLo);
    endtask

    task automatic writeReg(input bit h, input bit l, input logic [31:0] d);
        @(negedge clk);
        hi_we = h;
        lo_we = l;
        wdata = d;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (h) expHi = d;
        if (l) expLo = d;
        checkOutput("mtHi", hi, expHi);
        checkOutput("mtLo", lo, expLo);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int cyc;
        bit sawDone;
        reset = 1'b1;
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        op = MDU_MULT;
        a = '0;
        b = '0;
        wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetDone", done, 0);
        checkOutput("resetHi", hi, 0);
        checkOutput("resetLo", lo, 0);

        applyStimulus(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'd3, 32'd100, 32'd7, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'd3, 32'd5, 32'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(2'd2, 32'h8000_0007, 32'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'd0, 32'h0001_2345, 32'hFFFF_FF00, 1'b0, 1'b1, 1'b0);

        writeReg(1'b1, 1'b0, 32'h1234_5678);
        writeReg(1'b0, 1'b1, 32'h0BAD_CAFE);
        writeReg(1'b1, 1'b1, 32'h1111_1111);
        applyStimulus(2'd2, 32'd9, 32'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'd1, 32'd6, 32'd7, 1'b0, 1'b0, 1'b1);
        applyStimulus(2'd3, 32'd77, 32'd10, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            applyStimulus(2'($urandom_range(0, 3)), pickOperand(), pickOperand(),
                          1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        // Reset in the middle of a multiply must discard it entirely.
        writeReg(1'b1, 1'b0, 32'h1234_5678);
        @(negedge clk);
        start = 1'b1;
        op = MDU_MULT;
        a = 32'h0000_1234;
        b = 32'h0000_5678;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        checkOutput("busyMid", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        expHi = '0;
        expLo = '0;
        checkOutput("midResetBusy", busy, 0);
        checkOutput("midResetDone", done, 0);
        checkOutput("midResetHi", hi, expHi);
        checkOutput("midResetLo", lo, expLo);
        sawDone = 1'b0;
        for (cyc = 0; cyc < 40; cyc++) begin
            if (done === 1'b1 || busy === 1'b1) sawDone = 1'b1;
            @(negedge clk);
        end
        checkOutput("noDoneAfterReset", sawDone, 0);
        checkOutput("hiAfterReset", hi, expHi);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mdu.md
# mdu

Iterative multiply/divide unit for the EX stage of the pipelined MIPS core. It takes the same ID/EX operands `a`, `b` as the ALU and executes MULT, MULTU, DIV and DIVU over multiple cycles. Results go into architectural HI/LO registers, which feed the EX result mux for MFHI/MFLO. `busy` drives the hazard unit, which stalls IF/ID/EX while an operation is in flight.

## Interface
Parameters:
- `XLEN`, 32, operand width; HI/LO each `XLEN` bits.

Ports:
- `clk`  in  1  core clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  launch the operation in `op` on `a`, `b`; accepted only when `busy`=0.
- `op`  in  2  `mdu_op_t`: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  32  rs operand (multiplicand / dividend).
- `b`  in  32  rt operand (multiplier / divisor).
- `hi_we`  in  1  MTHI write strobe.
- `lo_we`  in  1  MTLO write strobe.
- `wdata`  in  32  MTHI/MTLO data.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse; HI/LO hold new results.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, ITER, POST. Reset: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter 0.
- IDLE with `start`=1:
  - Latch `op`.
  - Latch magnitudes of `a` and `b`; take the absolute value only for signed ops.
  - Latch result-sign flags: quotient/product sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Clear the 64-bit work register and counter; go to ITER.
- ITER, MULT/MULTU: radix-2 shift-add, one multiplier bit per cycle, LSB first, 64-bit accumulator.
- ITER, DIV/DIVU: restoring division, one quotient bit per cycle.
  - Shift {rem,quo} left one bit.
  - Trial-subtract the divisor using 33-bit arithmetic.
  - Keep the difference if it is non-negative.
- ITER ends after exactly 32 iterations; counter 0..31, then go to POST.
- POST:
  - Apply the sign flags with two's-complement negation. Multiply negates the full 64-bit product; divide negates quotient and remainder independently.
  - Write HI/LO: multiply gives HI=product[63:32], LO=product[31:0]; divide gives LO=quotient, HI=remainder.
  - Go to IDLE and assert `done` for the following cycle.
- Divide by zero, required values: HI=`a` (unmodified dividend), LO=0xFFFFFFFF, same latency. These values fall out of the restoring algorithm with the sign fix suppressed.
- DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0. Magnitudes are handled as 32-bit unsigned, so no special case is needed.
- `start` while `busy`=1: ignored; the operation in flight is undisturbed.
- `hi_we`/`lo_we`:
  - Applied at the clock edge only when in IDLE and `start`=0.
  - Dropped while busy or when `start` is asserted in the same cycle; `start` wins.
  - `hi_we` and `lo_we` together write both registers.
- `reset` at any time, including mid-operation: returns to the reset state at the next edge, and the partial result is discarded.

## Timing
- `start` sampled at edge N:
  - `busy`=1 from after edge N to after edge N+33.
  - ITER runs edges N+1..N+32.
  - POST writes HI/LO at edge N+33.
  - `done`=1 for exactly one cycle, after edge N+33.
- Back-to-back: a new `start` may be accepted in the `done` cycle (sampled at edge N+34).
- HI/LO are stable and unchanged from edge N through edge N+32. Reads during `busy` return the previous results.
- The MTHI/MTLO write is visible on `hi`/`lo` the cycle after the strobe edge.
- `busy` and `done` are registered outputs with no combinational path from inputs.

## Configuration
- `MDU_DIV_EN` defined: DIV/DIVU are implemented as specified above.
- `MDU_DIV_EN` undefined:
  - Divide logic is removed.
  - DIV/DIVU `start` gives no busy period (`busy` stays 0) and `done` pulses the next cycle.
  - HI/LO are unchanged.
  - MULT/MULTU are unaffected.

## Structure
- Shared package `mips_pkg` holds:
  - `mdu_op_t` (2-bit enum: MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU).
  - `mdu_state_t` (IDLE, ITER, POST).
  - constant `MDU_ITERS`=32.
- One sub-module, `mdu_div_step`: a combinational single restoring-division step (33-bit trial subtract, next remainder, quotient bit). It is instantiated only under `MDU_DIV_EN`. The shift-add multiply step stays inline.

## Test plan
- MULT a=0xFFFFFFFD (-3), b=7 → `done` after edge N+33; HI=0xFFFFFFFF, LO=0xFFFFFFEB; `busy` high exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; then DIVU a=100, b=7 issued in the `done` cycle → LO=14, HI=2.
- DIV a=0xFFFFFFF9 (-7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU a=5, b=0 → HI=5, LO=0xFFFFFFFF; `start` and `hi_we` re-pulsed mid-operation → ignored, results unchanged.
- MTHI 0x12345678 in IDLE → `hi`=0x12345678 next cycle; MULT started, `reset` asserted at cycle 10 of busy → `busy`=0, `done`=0, `hi`=`lo`=0; no `done` pulse ever appears.
- Build without `MDU_DIV_EN`: DIV a=9, b=3 with HI=LO=0x11111111 → `done` pulses next cycle, `busy` stays 0, HI/LO unchanged.
